// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM memory bus arbiter.
// State and owner codes are exported so checkers can bind to them by name.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } arb_owner_e;

    localparam int STALL_W           = 6;
    localparam int IF_STALL_BIT_DEF  = 1;
    localparam int MEM_STALL_BIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_buf.sv
// Result buffer for one requester: captures bus data on load and holds it
// until the owning pipeline stage advances (hold low) or a clear discards it.
module mem_arbiter_buf #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clear,
    input  logic              hold,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && !hold) begin
            // Stage advanced this edge: result consumed, data left stable.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between the IF and MEM stages: one transaction at a
// time, MEM has priority, each stage's result is buffered until it advances.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int IF_STALL_BIT  = IF_STALL_BIT_DEF,
    parameter int MEM_STALL_BIT = MEM_STALL_BIT_DEF,
    parameter int SEL_W         = DATA_W / 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               if_req_i,
    input  logic [ADDR_W-1:0]  if_addr_i,
    output logic [DATA_W-1:0]  if_data_o,
    output logic               stallreq_from_if,
    input  logic               mem_req_i,
    input  logic               mem_we_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic [SEL_W-1:0]   mem_sel_i,
    output logic [DATA_W-1:0]  mem_data_o,
    output logic               stallreq_from_mem,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    output logic               bus_req_o,
    output logic               bus_we_o,
    output logic [ADDR_W-1:0]  bus_addr_o,
    output logic [DATA_W-1:0]  bus_wdata_o,
    output logic [SEL_W-1:0]   bus_sel_o,
    input  logic               bus_ack_i,
    input  logic [DATA_W-1:0]  bus_rdata_i,
    output arb_state_e         state_dbg
);

    // Handshake: a requester holds *_req_i until its stallreq drops; the
    // bus side sees bus_req_o with stable qualifiers until a one-cycle
    // bus_ack_i, which also carries bus_rdata_i.

    arb_state_e state, state_next;
    arb_owner_e owner, owner_next;
    logic       if_kill, if_kill_next;
    logic       grant_mem, grant_if;
    logic       ack_mem, ack_if;
    logic       if_buf_v, mem_buf_v;
    logic       if_load, mem_load;
    logic [DATA_W-1:0] mem_load_data;
    logic       unused_stall_bits;

    assign unused_stall_bits = ^stall_i;
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        owner_next = owner;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mem_req_i && !mem_buf_v) begin
                    grant_mem  = 1'b1;
                    state_next = ST_BUSY;
                    owner_next = OWN_MEM;
                end else if (if_req_i && !if_buf_v && !flush_i) begin
                    grant_if   = 1'b1;
                    state_next = ST_BUSY;
                    owner_next = OWN_IF;
                end
            end
            ST_BUSY: begin
                if (bus_ack_i) begin
                    state_next = ST_IDLE;
                    owner_next = OWN_NONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                owner_next = OWN_NONE;
            end
        endcase
    end

    assign ack_mem = (state == ST_BUSY) && (owner == OWN_MEM) && bus_ack_i;
    assign ack_if  = (state == ST_BUSY) && (owner == OWN_IF)  && bus_ack_i;

    // A fetch redirected by flush still completes on the bus; its data is dropped.
    always_comb begin
        if_kill_next = if_kill;
        if (ack_if)
            if_kill_next = 1'b0;
        else if (flush_i && (state == ST_BUSY) && (owner == OWN_IF))
            if_kill_next = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            if_kill <= 1'b0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            if_kill <= if_kill_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_sel_o   <= '0;
        end else if (grant_mem) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
            bus_sel_o   <= mem_sel_i;
        end else if (grant_if) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            bus_sel_o   <= '1;
        end else if (ack_mem || ack_if) begin
            bus_req_o   <= 1'b0;
        end
    end

    assign if_load       = ack_if && !if_kill && !flush_i;
    assign mem_load      = ack_mem;
    assign mem_load_data = bus_we_o ? '0 : bus_rdata_i;

    mem_arbiter_buf #(.DATA_W(DATA_W)) u_if_buf (
        .CLK       (CLK),
        .RST       (RST),
        .load      (if_load),
        .load_data (bus_rdata_i),
        .clear     (flush_i),
        .hold      (stall_i[IF_STALL_BIT]),
        .data      (if_data_o),
        .valid     (if_buf_v)
    );

    mem_arbiter_buf #(.DATA_W(DATA_W)) u_mem_buf (
        .CLK       (CLK),
        .RST       (RST),
        .load      (mem_load),
        .load_data (mem_load_data),
        .clear     (1'b0),
        .hold      (stall_i[MEM_STALL_BIT]),
        .data      (mem_data_o),
        .valid     (mem_buf_v)
    );

    assign stallreq_from_if  = if_req_i  && !if_buf_v;
    assign stallreq_from_mem = mem_req_i && !mem_buf_v;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after a rising edge,
// outputs are checked 2ns after it, with hand-computed expectations.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        stallreq_from_if;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_data_o;
    logic        stallreq_from_mem;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    arb_state_e  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK               (CLK),
        .RST               (RST),
        .if_req_i          (if_req_i),
        .if_addr_i         (if_addr_i),
        .if_data_o         (if_data_o),
        .stallreq_from_if  (stallreq_from_if),
        .mem_req_i         (mem_req_i),
        .mem_we_i          (mem_we_i),
        .mem_addr_i        (mem_addr_i),
        .mem_wdata_i       (mem_wdata_i),
        .mem_sel_i         (mem_sel_i),
        .mem_data_o        (mem_data_o),
        .stallreq_from_mem (stallreq_from_mem),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .bus_req_o         (bus_req_o),
        .bus_we_o          (bus_we_o),
        .bus_addr_o        (bus_addr_o),
        .bus_wdata_o       (bus_wdata_o),
        .bus_sel_o         (bus_sel_o),
        .bus_ack_i         (bus_ack_i),
        .bus_rdata_i       (bus_rdata_i),
        .state_dbg         (state_dbg)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        settle();
        check_eq("rst_bus_req", bus_req_o, 0);
        check_eq("rst_bus_addr", bus_addr_o, 0);
        check_eq("rst_if_data", if_data_o, 0);
        check_eq("rst_mem_data", mem_data_o, 0);
        check_eq("rst_state", state_dbg, ST_IDLE);

        // Fetch only: grant at c0, ack at c2, data valid at c3
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h0;
        settle();
        check_eq("f_stall_c0", stallreq_from_if, 1);
        tick();
        settle();
        check_eq("f_bus_req_c1", bus_req_o, 1);
        check_eq("f_bus_addr", bus_addr_o, 32'h0);
        check_eq("f_bus_we", bus_we_o, 0);
        check_eq("f_stall_c1", stallreq_from_if, 1);
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0013;
        settle();
        check_eq("f_stall_c2", stallreq_from_if, 1);
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        settle();
        check_eq("f_stall_c3", stallreq_from_if, 0);
        check_eq("f_if_data", if_data_o, 32'h13);
        check_eq("f_bus_req_c3", bus_req_o, 0);
        if_req_i = 1'b0;
        tick();
        settle();
        check_eq("f_idle", state_dbg, ST_IDLE);

        // Contention: MEM load wins, IF granted in the IDLE cycle after MEM ack
        if_req_i = 1'b1; if_addr_i = 32'h4;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100; mem_sel_i = 4'hF;
        tick();
        settle();
        check_eq("c_mem_addr", bus_addr_o, 32'h100);
        check_eq("c_mem_req", bus_req_o, 1);
        check_eq("c_stall_if", stallreq_from_if, 1);
        check_eq("c_stall_mem", stallreq_from_mem, 1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hAABB_CCDD;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        settle();
        check_eq("c_mem_stall_lo", stallreq_from_mem, 0);
        check_eq("c_mem_data", mem_data_o, 32'hAABB_CCDD);
        check_eq("c_gap_req", bus_req_o, 0);
        check_eq("c_gap_state", state_dbg, ST_IDLE);
        check_eq("c_if_wait", stallreq_from_if, 1);
        mem_req_i = 1'b0;
        tick();
        settle();
        check_eq("c_if_req", bus_req_o, 1);
        check_eq("c_if_addr", bus_addr_o, 32'h4);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0011;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        settle();
        check_eq("c_if_data", if_data_o, 32'h11);
        check_eq("c_if_stall_lo", stallreq_from_if, 0);
        check_eq("c_mem_data_kept", mem_data_o, 32'hAABB_CCDD);
        if_req_i = 1'b0;
        tick();

        // Held IF: result buffered while stall_i[1]=1 for 4 cycles
        if_req_i = 1'b1; if_addr_i = 32'h8;
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0022;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        stall_i = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("h_no_req_%0d", i), bus_req_o, 0);
            check_eq($sformatf("h_data_%0d", i), if_data_o, 32'h22);
            check_eq($sformatf("h_stall_%0d", i), stallreq_from_if, 0);
            tick();
        end
        settle();
        check_eq("h_still_valid", stallreq_from_if, 0);
        stall_i = '0; if_addr_i = 32'hC;
        tick();
        settle();
        check_eq("h_consumed", stallreq_from_if, 1);
        check_eq("h_grant_gap", bus_req_o, 0);
        tick();
        settle();
        check_eq("h_refetch_addr", bus_addr_o, 32'hC);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0033;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        settle();
        check_eq("h_new_data", if_data_o, 32'h33);
        if_req_i = 1'b0;
        tick();

        // Flush mid-fetch: DEADBEEF dropped, redirected fetch issued
        if_req_i = 1'b1; if_addr_i = 32'h10;
        tick();
        settle();
        check_eq("x_bus_req", bus_req_o, 1);
        flush_i = 1'b1; if_addr_i = 32'h40;
        settle();
        check_eq("x_stall_flush", stallreq_from_if, 1);
        tick();
        flush_i = 1'b0;
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
        settle();
        check_eq("x_stall_ack", stallreq_from_if, 1);
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        settle();
        check_eq("x_dropped_stall", stallreq_from_if, 1);
        check_eq("x_dropped_data", if_data_o, 32'h33);
        check_eq("x_bus_idle", bus_req_o, 0);
        tick();
        settle();
        check_eq("x_new_req", bus_req_o, 1);
        check_eq("x_new_addr", bus_addr_o, 32'h40);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0044;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        settle();
        check_eq("x_new_data", if_data_o, 32'h44);
        check_eq("x_new_stall", stallreq_from_if, 0);
        if_req_i = 1'b0;
        tick();

        // Store: qualifiers held until ack, load data reads as 0
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h200;
        mem_wdata_i = 32'h1234_5678; mem_sel_i = 4'hF;
        settle();
        check_eq("s_stall_c0", stallreq_from_mem, 1);
        tick();
        settle();
        check_eq("s_req", bus_req_o, 1);
        check_eq("s_we", bus_we_o, 1);
        check_eq("s_addr", bus_addr_o, 32'h200);
        check_eq("s_wdata", bus_wdata_o, 32'h1234_5678);
        check_eq("s_sel", bus_sel_o, 4'hF);
        tick();
        settle();
        check_eq("s_hold_req", bus_req_o, 1);
        check_eq("s_hold_wdata", bus_wdata_o, 32'h1234_5678);
        check_eq("s_hold_stall", stallreq_from_mem, 1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_9999;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        settle();
        check_eq("s_stall_lo", stallreq_from_mem, 0);
        check_eq("s_mem_data", mem_data_o, 32'h0);
        check_eq("s_req_lo", bus_req_o, 0);
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        tick();

        // Reset while BUSY, then a stray ack in IDLE
        if_req_i = 1'b1; if_addr_i = 32'h50;
        tick();
        settle();
        check_eq("r_busy_req", bus_req_o, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0; if_req_i = 1'b0;
        settle();
        check_eq("r_req_dropped", bus_req_o, 0);
        check_eq("r_state", state_dbg, ST_IDLE);
        check_eq("r_if_data", if_data_o, 0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0BAD;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        if_req_i = 1'b1; mem_req_i = 1'b1; mem_addr_i = 32'h300;
        settle();
        check_eq("r_stray_if_data", if_data_o, 0);
        check_eq("r_if_invalid", stallreq_from_if, 1);
        check_eq("r_mem_invalid", stallreq_from_mem, 1);
        check_eq("r_stray_state", state_dbg, ST_IDLE);
        if_req_i = 1'b0; mem_req_i = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
